// File: rtl/time_param_pkg.sv
// Shared types and constants for the programmable-time countdown timer.
package time_param_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int BASE = 0;
    localparam int EXT  = 1;
    localparam int YEL  = 2;

    localparam logic [3:0] DEF_BASE = 4'd6;
    localparam logic [3:0] DEF_EXT  = 4'd3;
    localparam logic [3:0] DEF_YEL  = 4'd2;

    // Index 0 occupies the least-significant nibble.
    localparam logic [11:0] DEF_BANK = {DEF_YEL, DEF_EXT, DEF_BASE};

endpackage

// File: rtl/time_param_bank.sv
// Programmable time-parameter register bank with restore, write and read mux.
// Define TIME_PARAM_ZERO_GUARD_EN to reject writes of zero to any parameter.
module time_param_bank
    import time_param_pkg::*;
#(
    parameter int TW     = 4,
    parameter int NPARAM = 3,
    parameter int SW     = $clog2(NPARAM + 1),
    parameter logic [NPARAM*TW-1:0] DEFAULTS = DEF_BANK
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_sel,
    input  logic [TW-1:0] wr_value,
    input  logic [SW-1:0] rd_sel,
    output logic [TW:0]   rd_value,
    output logic          reject
);

    localparam logic [SW-1:0] NP_CODE = SW'(NPARAM);

    logic [TW-1:0] params [NPARAM];
    logic          zero_reject;
    logic          sel_reject;

`ifdef TIME_PARAM_ZERO_GUARD_EN
    assign zero_reject = (wr_sel != '0) && (wr_sel <= NP_CODE) && (wr_value == '0);
`else
    assign zero_reject = 1'b0;
`endif

    assign sel_reject = wr_sel > NP_CODE;
    assign reject     = wr_en && (sel_reject || zero_reject);

    // NOTE: the bank is only a handful of flops, so every entry is reset to its
    // default; a large RAM-style bank would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPARAM; k++) params[k] <= DEFAULTS[k*TW +: TW];
        end else if (wr_en && !sel_reject && !zero_reject) begin
            if (wr_sel == '0) begin
                for (int k = 0; k < NPARAM; k++) params[k] <= DEFAULTS[k*TW +: TW];
            end else begin
                for (int k = 0; k < NPARAM; k++) begin
                    if (wr_sel == SW'(k + 1)) params[k] <= wr_value;
                end
            end
        end
    end

    // Reads see the current (pre-write) contents, so a same-cycle load gets the old value.
    // NOTE: rd_value is defaulted first so no path through the loop can infer a latch.
    always_comb begin
        rd_value = '0;
        if (rd_sel == NP_CODE) begin
            rd_value = {params[BASE], 1'b0};
        end else begin
            for (int k = 0; k < NPARAM; k++) begin
                if (rd_sel == SW'(k)) rd_value = {1'b0, params[k]};
            end
        end
    end

endmodule

// File: rtl/time_param_timer.sv
// Tick-driven countdown timer loading from a programmable parameter bank.
// Optional TIME_PARAM_ZERO_GUARD_EN (in time_param_bank) rejects zero writes.
module time_param_timer
    import time_param_pkg::*;
#(
    parameter int TW     = 4,
    parameter int NPARAM = 3,
    parameter logic [NPARAM*TW-1:0] DEFAULTS = DEF_BANK,
    localparam int SW    = $clog2(NPARAM + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          prog_valid,
    input  logic [SW-1:0] prog_sel,
    input  logic [TW-1:0] prog_value,
    output logic          prog_ready,
    input  logic          start,
    input  logic [SW-1:0] interval,
    input  logic          cancel,
    output logic          busy,
    output logic [TW:0]   remaining,
    output logic          expired,
    output logic          err
);

    localparam logic [SW-1:0] NP_CODE = SW'(NPARAM);
    localparam logic [TW:0]   ONE     = (TW + 1)'(1);

    state_t      state_q, state_d;
    logic [TW:0] remaining_q, remaining_d;
    logic        expired_q, expired_d;
    logic        err_q;
    logic        ready_q;
    logic [TW:0] load_value;
    logic        bank_reject;
    logic        wr_en;
    logic        start_ok;
    logic        start_bad;

    assign wr_en     = prog_valid && ready_q;
    assign start_ok  = start && (interval <= NP_CODE);
    assign start_bad = start && (interval > NP_CODE);

    time_param_bank #(
        .TW       (TW),
        .NPARAM   (NPARAM),
        .SW       (SW),
        .DEFAULTS (DEFAULTS)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_sel   (prog_sel),
        .wr_value (prog_value),
        .rd_sel   (interval),
        .rd_value (load_value),
        .reject   (bank_reject)
    );

    // Priority: cancel, then a legal start, then a tick while running.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        if (cancel) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else if (start_ok) begin
            state_d     = RUN;
            remaining_d = load_value;
        end else if (state_q == RUN && tick) begin
            if (remaining_q <= ONE) begin
                state_d     = IDLE;
                remaining_d = '0;
                expired_d   = 1'b1;
            end else begin
                remaining_d = remaining_q - ONE;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            err_q       <= bank_reject || start_bad;
            ready_q     <= 1'b1;
        end
    end

    assign busy       = (state_q == RUN);
    assign remaining  = remaining_q;
    assign expired    = expired_q;
    assign err        = err_q;
    assign prog_ready = ready_q;

endmodule
